seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. Successor to the fixed 4-bit Mealy detector.
- Pattern, length, overlap policy and Mealy/Moore output timing are all run-time configurable.
- Counts matches with a saturating counter.
- Sits on a 1-bit serial input stream. Used by later guia exercises and as a reusable frame-marker finder.

Parameters:
- N, 8, maximum pattern length in bits (2..16)
- CW, 8, width of match counter
- LW, $clog2(N+1), width of the plen field (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- x  input  1  serial data bit
- in_valid  input  1  x is consumed on this rising edge when 1
- cfg_load  input  1  latch configuration and clear detector state
- cfg_pattern  input  N  pattern; bit 0 is the first bit expected on x
- cfg_plen  input  LW  active pattern length, 1..N; 0 or >N disables detection
- cfg_overlap  input  1  1 = overlapping matches allowed
- cfg_moore  input  1  1 = registered (Moore) output, 0 = combinational (Mealy)
- y  output  1  match pulse
- match_count  output  CW  saturating number of matches since reset/cfg_load
- state_k  output  LW  current matched-prefix length (debug)

Behaviour:
- Reset (reset=0, async):
  - state_k=0, match_count=0, Moore y register=0.
  - Config registers: pattern=0, plen=0 (disabled), overlap=0, moore=0.
  - y=0 throughout reset.
- Config:
  - cfg_* are sampled only on a rising edge with cfg_load=1.
  - The same edge forces state_k=0, match_count=0 and Moore y=0.
  - cfg_load has priority over in_valid; the x bit on that edge is dropped.
  - cfg_* changes without cfg_load have no effect.
- Meaning of state_k: length k of the longest suffix of bits consumed since the last clear that equals pattern[0..k-1], with k<plen.
- Step on in_valid=1, with current state k:
  - If x==pattern[k]: candidate c=k+1.
  - Else: c = longest j<=k such that pattern[0..j-2] equals the last j-1 consumed bits and pattern[j-1]==x (KMP fallback; 0 if none).
  - match = (c==plen) and plen valid.
  - On match with overlap=1: next state = longest proper border of pattern[0..plen-1].
  - On match with overlap=0: next state = 0.
  - Otherwise: next state = c.
- in_valid=0: state, count and Moore y hold/clear per the rules below; no bit consumed.
- Mealy (moore=0):
  - y = in_valid & match, combinational, in the same cycle as the completing bit.
  - Decoding must not glitch y while in_valid=0.
- Moore (moore=1):
  - y is a register loaded with match on each edge; 0 on edges with in_valid=0.
  - y is therefore high for exactly one cycle, one cycle after the completing bit.
- Counter: match_count increments by 1 on each matching edge; it holds at 2^CW-1 (no wrap).
- Disabled (plen=0 or plen>N): state_k stays 0, y=0, count holds.
- plen=1: every bit equal to pattern[0] is a match. Overlap is irrelevant because the border is 0.
- Reset asserted mid-pattern: state is lost immediately; the first bit after release starts from k=0.
- Undefined state_k>=plen (unreachable) must recover to 0 on the next edge.

Decomposition:
- Shared package seq_det_pkg:
  - constants FOUND=1'b1 and NOTFOUND=1'b0.
  - output-mode enum {MODE_MEALY, MODE_MOORE}.
- Sub-module seq_next_state (combinational):
  - Inputs: k, x, pattern, plen, overlap.
  - Outputs: next_k, match.
  - Implements fallback and border logic via a loop over N.
- Top module holds config registers, state_k, counter and Moore y register.

Test Plan:
- Pattern/stream, N=8, cfg_pattern=8'b0000_0100, plen=4 (sequence 0,0,1,0):
  - overlap=1, Mealy, stream 0,0,1,0,0,1,0 -> y=1 on bits 4 and 7; match_count=2.
- Non-overlap: same config with overlap=0 -> y=1 only on bit 4; match_count=1.
- Moore timing: same config as the overlap=1 case with moore=1 -> y=1 one cycle after bits 4 and 7, each pulse one cycle wide; in_valid gap of 3 cycles mid-stream does not break the match.
- Saturation, CW=2:
  - Pattern "1", plen=1, stream of six 1s -> count 1,2,3,3,3,3.
  - Then cfg_load -> count=0 and state_k=0 on the next edge.
- Priority/disable:
  - cfg_load and in_valid on the same edge -> bit ignored, state_k=0.
  - plen=0, any stream -> y=0, count stays 0.
- Async reset:
  - After 0,0,1 (state_k=3), pulse reset low for 3 ns between edges -> state_k=0 and y=0 immediately; config cleared.
  - Reload config, then send 0 -> state_k=1 on that edge; a following 0,0 gives no false match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam logic FOUND    = 1'b1;
    localparam logic NOTFOUND = 1'b0;

    typedef enum logic {
        MODE_MEALY = 1'b0,
        MODE_MOORE = 1'b1
    } mode_e;

endpackage

// File: rtl/seq_next_state.sv
// Combinational KMP step: from the matched-prefix length and the incoming bit,
// derive the next prefix length and whether the active pattern just completed.
module seq_next_state
    import seq_det_pkg::*;
#(
    parameter int N  = 8,
    parameter int LW = $clog2(N + 1)
) (
    input  logic [LW-1:0] k_i,
    input  logic          x_i,
    input  logic [N-1:0]  pattern_i,
    input  logic [LW-1:0] plen_i,
    input  logic          overlap_i,
    output logic [LW-1:0] next_k_o,
    output logic          match_o
);

    function automatic logic bit_at(input logic [N-1:0] p, input int idx);
        logic [N-1:0] s;
        if (idx < 0 || idx >= N) return 1'b0;
        s = p >> idx;
        return s[0];
    endfunction

    // NOTE: every output and temporary gets a value before any branch, so no
    // path through this block can leave a stale value (no latch is inferred).
    always_comb begin
        int   k;
        int   pl;
        int   cand;
        int   border;
        logic same;

        k        = int'(k_i);
        pl       = int'(plen_i);
        cand     = 0;
        border   = 0;
        same     = 1'b0;
        next_k_o = '0;
        match_o  = NOTFOUND;

        // An out-of-range state or a disabled length falls through to k=0.
        if (pl >= 1 && pl <= N && k < pl) begin
            if (bit_at(pattern_i, k) == x_i) begin
                cand = k + 1;
            end else begin
                for (int j = 1; j <= N; j++) begin
                    if (j <= k && bit_at(pattern_i, j - 1) == x_i) begin
                        same = 1'b1;
                        for (int i = 0; i < N - 1; i++) begin
                            if (i <= j - 2 &&
                                bit_at(pattern_i, i) != bit_at(pattern_i, k - j + 1 + i))
                                same = 1'b0;
                        end
                        if (same) cand = j;
                    end
                end
            end

            // Longest proper border of the active pattern, used to resume after an overlapping hit.
            for (int b = 1; b < N; b++) begin
                same = 1'b1;
                for (int i = 0; i < N - 1; i++) begin
                    if (i < b && bit_at(pattern_i, i) != bit_at(pattern_i, pl - b + i))
                        same = 1'b0;
                end
                if (b < pl && same) border = b;
            end

            if (cand == pl) begin
                match_o  = FOUND;
                next_k_o = overlap_i ? LW'(border) : '0;
            end else begin
                next_k_o = LW'(cand);
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with Mealy/Moore output
// selection and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 8,
    parameter int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x,
    input  logic          in_valid,
    input  logic          cfg_load,
    input  logic [N-1:0]  cfg_pattern,
    input  logic [LW-1:0] cfg_plen,
    input  logic          cfg_overlap,
    input  logic          cfg_moore,
    output logic          y,
    output logic [CW-1:0] match_count,
    output logic [LW-1:0] state_k
);

    logic [N-1:0]  pattern_q, pattern_d;
    logic [LW-1:0] plen_q, plen_d;
    logic          overlap_q, overlap_d;
    mode_e         mode_q, mode_d;
    logic [LW-1:0] k_q, k_d;
    logic [CW-1:0] count_q, count_d;
    logic          y_q, y_d;

    logic [LW-1:0] step_k;
    logic          step_match;

    seq_next_state #(
        .N  (N),
        .LW (LW)
    ) u_next (
        .k_i       (k_q),
        .x_i       (x),
        .pattern_i (pattern_q),
        .plen_i    (plen_q),
        .overlap_i (overlap_q),
        .next_k_o  (step_k),
        .match_o   (step_match)
    );

    always_comb begin
        pattern_d = pattern_q;
        plen_d    = plen_q;
        overlap_d = overlap_q;
        mode_d    = mode_q;
        k_d       = k_q;
        count_d   = count_q;
        y_d       = NOTFOUND;

        // Loading configuration wins over data; the bit on that edge is discarded.
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            plen_d    = cfg_plen;
            overlap_d = cfg_overlap;
            mode_d    = cfg_moore ? MODE_MOORE : MODE_MEALY;
            k_d       = '0;
            count_d   = '0;
        end else if (in_valid) begin
            k_d = step_k;
            y_d = step_match;
            if (step_match && count_q != '1) count_d = count_q + CW'(1);
        end else if (k_q >= plen_q) begin
            k_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q <= '0;
            plen_q    <= '0;
            overlap_q <= 1'b0;
            mode_q    <= MODE_MEALY;
            k_q       <= '0;
            count_q   <= '0;
            y_q       <= NOTFOUND;
        end else begin
            pattern_q <= pattern_d;
            plen_q    <= plen_d;
            overlap_q <= overlap_d;
            mode_q    <= mode_d;
            k_q       <= k_d;
            count_q   <= count_d;
            y_q       <= y_d;
        end
    end

    // The Mealy term is qualified by in_valid so a changing x cannot pulse y while idle.
    assign y = (mode_q == MODE_MOORE) ? y_q
                                      : (reset & ~cfg_load & in_valid & step_match);
    assign match_count = count_q;
    assign state_k     = k_q;

endmodule
